// File: rtl/teamd_pkg.sv
// Shared constants and types for the TEAMD result path.
package teamd_pkg;

  localparam int unsigned TEAMD_WORD_W    = 5;
  localparam int unsigned TEAMD_CARRY_BIT = 1;
  localparam int unsigned TEAMD_DEPTH_DEF = 2;
  localparam int unsigned TEAMD_CNT_W_DEF = 4;

  typedef logic [TEAMD_WORD_W-1:0] teamd_word_t;

endpackage : teamd_pkg

// File: rtl/teamd_sat_counter.sv
// Increment-enable counter that holds at all-ones instead of wrapping.
module teamd_sat_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled events, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule : teamd_sat_counter

// File: rtl/teamd_result_buffer.sv
// Registered FIFO stage behind TEAMD_DESIGN with VALID/ACK handshake,
// sticky overflow flag and saturating carry-event counter.
module teamd_result_buffer
  import teamd_pkg::*;
#(
  parameter int unsigned DEPTH = TEAMD_DEPTH_DEF,
  parameter int unsigned CNT_W = TEAMD_CNT_W_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             D0,
  input  logic             D1,
  input  logic             D2,
  input  logic             D3,
  input  logic             D4,
  input  logic             LOAD,
  input  logic             ACK,
  output logic             R0,
  output logic             R1,
  output logic             R2,
  output logic             R3,
  output logic             R4,
  output logic             VALID,
  output logic             FULL,
  output logic             DROP,
  output logic [CNT_W-1:0] CARRYCNT
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  teamd_word_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n;
  logic [OCC_W-1:0] occ_q, occ_n;
  logic             valid_q, full_q, drop_q;
  teamd_word_t      r_q, head_n, d_word;
  logic             push, pop, drop_evt;

  // Decode push/pop/overflow and compute next occupancy, pointers and head word.
  always_comb begin
    d_word   = {D4, D3, D2, D1, D0};
    push     = LOAD && (!full_q || ACK);
    pop      = ACK && valid_q;
    drop_evt = LOAD && full_q && !ACK;

    occ_n    = occ_q;
    wr_ptr_n = wr_ptr_q;
    rd_ptr_n = rd_ptr_q;
    head_n   = '0;

    if (push && !pop) begin
      occ_n = occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_n = occ_q - OCC_W'(1);
    end
    if (push) wr_ptr_n = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_n = rd_ptr_q + PTR_W'(1);

    // Word written this cycle becomes the head when it lands at the new read pointer.
    if (occ_n != '0) begin
      if (push && (wr_ptr_q == rd_ptr_n)) begin
        head_n = d_word;
      end else begin
        head_n = mem_q[rd_ptr_n];
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= d_word;
    end
  end

  // Pointers, occupancy and registered status/head outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
      r_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_n;
      rd_ptr_q <= rd_ptr_n;
      occ_q    <= occ_n;
      valid_q  <= (occ_n != '0);
      full_q   <= (occ_n == OCC_W'(DEPTH));
      drop_q   <= drop_q | drop_evt;
      r_q      <= head_n;
    end
  end

  teamd_sat_counter #(
    .W (CNT_W)
  ) u_carry_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .en    (push && d_word[TEAMD_CARRY_BIT]),
    .count (CARRYCNT)
  );

  assign {R4, R3, R2, R1, R0} = r_q;
  assign VALID = valid_q;
  assign FULL  = full_q;
  assign DROP  = drop_q;

endmodule : teamd_result_buffer

// File: tb/tb_teamd_result_buffer.sv
// Self-checking bench for teamd_result_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_teamd_result_buffer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic Clock = 1'b0;
  logic Reset, LOAD, ACK;
  logic D0, D1, D2, D3, D4;
  logic R0, R1, R2, R3, R4;
  logic VALID, FULL, DROP;
  logic [CNT_W-1:0] CARRYCNT;
  logic [4:0] r_word;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [4:0] m_q[$];
  logic       m_drop;
  int         m_cnt;

  teamd_result_buffer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .D0       (D0),
    .D1       (D1),
    .D2       (D2),
    .D3       (D3),
    .D4       (D4),
    .LOAD     (LOAD),
    .ACK      (ACK),
    .R0       (R0),
    .R1       (R1),
    .R2       (R2),
    .R3       (R3),
    .R4       (R4),
    .VALID    (VALID),
    .FULL     (FULL),
    .DROP     (DROP),
    .CARRYCNT (CARRYCNT)
  );

  always #5 Clock = ~Clock;

  assign r_word = {R4, R3, R2, R1, R0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic ld, input logic ak, input logic [4:0] d);
    bit full, push, pop;
    if (rst) begin
      m_q.delete();
      m_drop = 1'b0;
      m_cnt  = 0;
    end else begin
      full = (m_q.size() == DEPTH);
      push = ld && (!full || ak);
      pop  = ak && (m_q.size() != 0);
      if (ld && full && !ak) m_drop = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(d);
        if (d[1] && m_cnt < CNT_MAX) m_cnt++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [4:0] exp_r;
    exp_r = (m_q.size() != 0) ? m_q[0] : 5'b0;
    check({tag, "_R"},     32'(r_word),   32'(exp_r));
    check({tag, "_VALID"}, 32'(VALID),    32'(m_q.size() != 0));
    check({tag, "_FULL"},  32'(FULL),     32'(m_q.size() == DEPTH));
    check({tag, "_DROP"},  32'(DROP),     32'(m_drop));
    check({tag, "_CNT"},   32'(CARRYCNT), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge.
  task automatic step(input string tag, input logic rst, input logic ld, input logic ak,
                      input logic [4:0] d);
    Reset = rst;
    LOAD  = ld;
    ACK   = ak;
    {D4, D3, D2, D1, D0} = d;
    @(posedge Clock);
    model_update(rst, ld, ak, d);
    @(negedge Clock);
    compare_all(tag);
  endtask

  initial begin
    Reset = 1'b1; LOAD = 1'b0; ACK = 1'b0;
    {D4, D3, D2, D1, D0} = 5'b0;
    m_drop = 1'b0;
    m_cnt  = 0;
    @(negedge Clock);

    // 1: reset with LOAD asserted
    step("t1_rst", 1'b1, 1'b1, 1'b0, 5'b10110);
    step("t1_rst", 1'b1, 1'b1, 1'b0, 5'b10110);
    step("t1_idle", 1'b0, 1'b0, 1'b0, 5'b00000);
    check("t1_VALID0", 32'(VALID), 32'd0);
    check("t1_CNT0", 32'(CARRYCNT), 32'd0);

    // 2: single push then pop
    step("t2_push", 1'b0, 1'b1, 1'b0, 5'b00011);
    check("t2_Rval", 32'(r_word), 32'h03);
    check("t2_CNT1", 32'(CARRYCNT), 32'd1);
    step("t2_hold", 1'b0, 1'b0, 1'b0, 5'b11111);
    step("t2_pop", 1'b0, 1'b0, 1'b1, 5'b00000);
    check("t2_empty", 32'(VALID), 32'd0);

    // 3: fill, overflow, drain
    step("t3_p1", 1'b0, 1'b1, 1'b0, 5'b01010);
    step("t3_p2", 1'b0, 1'b1, 1'b0, 5'b00101);
    step("t3_ovf", 1'b0, 1'b1, 1'b0, 5'b11111);
    check("t3_FULL", 32'(FULL), 32'd1);
    check("t3_DROP", 32'(DROP), 32'd1);
    check("t3_head", 32'(r_word), 32'h0A);
    step("t3_pop1", 1'b0, 1'b0, 1'b1, 5'b00000);
    check("t3_head2", 32'(r_word), 32'h05);
    step("t3_pop2", 1'b0, 1'b0, 1'b1, 5'b00000);

    // 4: full with simultaneous LOAD+ACK
    step("t4_rst", 1'b1, 1'b0, 1'b0, 5'b00000);
    step("t4_p1", 1'b0, 1'b1, 1'b0, 5'b01010);
    step("t4_p2", 1'b0, 1'b1, 1'b0, 5'b00101);
    step("t4_both", 1'b0, 1'b1, 1'b1, 5'b10011);
    check("t4_FULL", 32'(FULL), 32'd1);
    check("t4_DROP", 32'(DROP), 32'd0);
    check("t4_head", 32'(r_word), 32'h05);
    step("t4_pop", 1'b0, 1'b0, 1'b1, 5'b00000);
    check("t4_tail", 32'(r_word), 32'h13);

    // 5: carry counter saturation
    step("t5_rst", 1'b1, 1'b0, 1'b0, 5'b00000);
    for (int i = 0; i < 20; i++) step("t5_sat", 1'b0, 1'b1, 1'b1, 5'b00010);
    check("t5_CNT15", 32'(CARRYCNT), 32'd15);

    // 6: reset mid-operation
    step("t6_rst", 1'b1, 1'b0, 1'b0, 5'b00000);
    step("t6_a", 1'b0, 1'b1, 1'b0, 5'b00010);
    step("t6_b", 1'b0, 1'b0, 1'b1, 5'b00000);
    step("t6_c", 1'b0, 1'b1, 1'b0, 5'b00011);
    step("t6_d", 1'b0, 1'b1, 1'b0, 5'b00110);
    step("t6_e", 1'b0, 1'b1, 1'b0, 5'b11111);
    check("t6_pre_CNT", 32'(CARRYCNT), 32'd3);
    check("t6_pre_DROP", 32'(DROP), 32'd1);
    step("t6_rst", 1'b1, 1'b1, 1'b1, 5'b11111);
    check("t6_R0", 32'(r_word), 32'd0);
    check("t6_FULL0", 32'(FULL), 32'd0);
    check("t6_DROP0", 32'(DROP), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 1) == 1), 5'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_teamd_result_buffer
